expr_eval: RTL
==============

# expr_eval

Downstream consumer of the character-stream expression checker. Takes the same 8-bit ASCII stream, one character per valid cycle, and evaluates expressions of single decimal digits joined by `+` and `*` with normal precedence (`*` binds tighter). Each expression ends with `=`. The block reports the result, or an error flag for malformed input. It sits after the checker on the same `in` bus, so arithmetic is available once a well-formed expression completes.

## Interface
- `W`, default 16: width of result and accumulators; all arithmetic is modulo 2^W.
- `clk`, in, 1: single clock, rising edge.
- `clr`, in, 1: reset, asynchronous, active-low; clears all state and outputs.
- `in_valid`, in, 1: `in` carries a character this cycle.
- `in`, in, 8: ASCII character.
- `result`, out, W: value of the last completed expression; holds until the next `done`.
- `done`, out, 1: one-cycle pulse when an expression has been terminated by `=`.
- `err`, out, 1: qualifies `done`; 1 means the expression was malformed. Holds with `result`.

## Operation
- Character classes:
  - DIGIT: `0`..`9`.
  - OP: `+` or `*`.
  - EQ: `=`.
  - Anything else is INVALID.
- Cycles with `in_valid=0` are ignored. State and accumulators are unchanged.
- Accumulators, both W bits:
  - `sum`: committed terms.
  - `prod`: current term.
  - `pend_mul` flag: next digit multiplies.
- FSM states: `EXP_DIGIT` (reset state), `EXP_OP`, `ERR`.
- Transitions in `EXP_DIGIT`:
  - DIGIT d: `prod <= pend_mul ? prod*d : d`, go to `EXP_OP`.
  - OP, EQ or INVALID: go to `ERR`.
  - EQ here (for example `=` alone, or `3+=`) terminates the expression with an error: `done` pulses, `err=1`, `result=0`. Accumulators clear and the state returns to `EXP_DIGIT`. It does not stay in `ERR`.
- Transitions in `EXP_OP`:
  - `+`: `sum <= sum+prod`, `pend_mul <= 0`, go to `EXP_DIGIT`.
  - `*`: `pend_mul <= 1`, go to `EXP_DIGIT`.
  - EQ: `result <= sum+prod`, `err <= 0`, `done` pulses. Clear `sum`, `prod` and `pend_mul`; go to `EXP_DIGIT`.
  - DIGIT or INVALID: go to `ERR`. Two adjacent digits are an error; operands are single-digit only.
- Transitions in `ERR`:
  - Every character except EQ is absorbed.
  - EQ: `done` pulses, `err <= 1`, `result <= 0`, accumulators clear, go to `EXP_DIGIT`.
- Width rules:
  - Digit value is `in - 8'h30`, zero-extended to W.
  - Products and sums are truncated to W bits at every step; there is no overflow flag.
- Reset (`clr` low, any time, including mid-expression):
  - `result=0`, `err=0`, `done=0`.
  - `sum=0`, `prod=0`, `pend_mul=0`.
  - State `EXP_DIGIT`.
  - The partial expression is discarded and produces no `done`.

## Timing
- All outputs are registered.
- `done`, `result` and `err` update on the rising edge that samples the valid `=`. They are visible in the cycle after `=` is presented: latency 1.
- `done` is high for exactly one cycle per `=`.
- A new expression may begin in the cycle immediately after `=`, with no dead cycle. That first character is processed normally while `done` is high.
- `in_valid` may drop at any point inside an expression. Gaps of any length do not affect the result.
- Reset deassertion is synchronised by the user. The first valid character is sampled on the first rising edge with `clr` high.

## Test plan
- Precedence, left term multiplied: `3*2+5=` on consecutive cycles -> one cycle after `=`: `done=1`, `result=11`, `err=0`; `done=0` in the next cycle and `result` holds at 11.
- Precedence, right term multiplied: `2+3*4=` -> `result=14`. Then immediately `1*0+7=` -> `result=7`, with a single `done` pulse for each expression.
- Malformed input:
  - `3+*=` -> `done=1`, `err=1`, `result=0`.
  - `35=` -> `err=1`.
  - `=` alone -> `err=1`.
  - `3a+1=` -> `err=1`.
  - The next expression `1+1=` -> `result=2`, `err=0`.
- Wrap-around with W=8: `9*9*9*9=` -> `result=161` (6561 mod 256), `err=0`.
- Asynchronous reset mid-expression: `3*` then pulse `clr` low between clock edges -> outputs are 0 immediately. Then `7+1=` -> `result=8`, showing no leftover `pend_mul` or `prod`.
- Valid gaps: `8*` then `in_valid=0` for 5 cycles while `in` toggles garbage, then `2=` -> `result=16`, `err=0`.

Source files
------------

// File: rtl/expr_eval.sv
// Streaming evaluator for single-digit '+'/'*' expressions terminated by '='.
// Reports the modulo-2^W result or an error flag one cycle after each '='.
module expr_eval #(
  parameter int unsigned W = 16
) (
  input  logic         clk,
  input  logic         clr,
  input  logic         in_valid,
  input  logic [7:0]   in,
  output logic [W-1:0] result,
  output logic         done,
  output logic         err
);

  typedef enum logic [1:0] {
    EXP_DIGIT = 2'd0,
    EXP_OP    = 2'd1,
    ERR       = 2'd2
  } state_t;

  localparam logic [7:0] CH_0    = 8'h30;
  localparam logic [7:0] CH_9    = 8'h39;
  localparam logic [7:0] CH_PLUS = 8'h2B;
  localparam logic [7:0] CH_MUL  = 8'h2A;
  localparam logic [7:0] CH_EQ   = 8'h3D;

  state_t       state, state_next;
  logic [W-1:0] sum, sum_next;
  logic [W-1:0] prod, prod_next;
  logic         pend_mul, pend_mul_next;
  logic [W-1:0] result_next;
  logic         done_next, err_next;

  logic         is_digit_c, is_eq_c;
  logic [3:0]   digit_c;
  logic [W-1:0] digit_w_c;

  // Character classification and digit value.
  always_comb begin
    is_digit_c = (in >= CH_0) && (in <= CH_9);
    is_eq_c    = (in == CH_EQ);
    digit_c    = 4'(in - CH_0);
    digit_w_c  = W'(digit_c);
  end

  // Next-state and next-register values; '=' always ends an expression.
  always_comb begin
    state_next    = state;
    sum_next      = sum;
    prod_next     = prod;
    pend_mul_next = pend_mul;
    result_next   = result;
    err_next      = err;
    done_next     = 1'b0;

    if (in_valid) begin
      case (state)
        EXP_DIGIT: begin
          if (is_digit_c) begin
            prod_next  = pend_mul ? W'(prod * digit_w_c) : digit_w_c;
            state_next = EXP_OP;
          end else if (is_eq_c) begin
            done_next     = 1'b1;
            err_next      = 1'b1;
            result_next   = '0;
            sum_next      = '0;
            prod_next     = '0;
            pend_mul_next = 1'b0;
            state_next    = EXP_DIGIT;
          end else begin
            state_next = ERR;
          end
        end
        EXP_OP: begin
          if (is_eq_c) begin
            done_next     = 1'b1;
            err_next      = 1'b0;
            result_next   = W'(sum + prod);
            sum_next      = '0;
            prod_next     = '0;
            pend_mul_next = 1'b0;
            state_next    = EXP_DIGIT;
          end else if (in == CH_PLUS) begin
            sum_next      = W'(sum + prod);
            pend_mul_next = 1'b0;
            state_next    = EXP_DIGIT;
          end else if (in == CH_MUL) begin
            pend_mul_next = 1'b1;
            state_next    = EXP_DIGIT;
          end else begin
            state_next = ERR;
          end
        end
        ERR: begin
          // Swallow everything up to the terminating '='.
          if (is_eq_c) begin
            done_next     = 1'b1;
            err_next      = 1'b1;
            result_next   = '0;
            sum_next      = '0;
            prod_next     = '0;
            pend_mul_next = 1'b0;
            state_next    = EXP_DIGIT;
          end
        end
        default: begin
          state_next = EXP_DIGIT;
        end
      endcase
    end
  end

  // State, accumulators and registered outputs.
  always_ff @(posedge clk or negedge clr) begin
    if (!clr) begin
      state    <= EXP_DIGIT;
      sum      <= '0;
      prod     <= '0;
      pend_mul <= 1'b0;
      result   <= '0;
      done     <= 1'b0;
      err      <= 1'b0;
    end else begin
      state    <= state_next;
      sum      <= sum_next;
      prod     <= prod_next;
      pend_mul <= pend_mul_next;
      result   <= result_next;
      done     <= done_next;
      err      <= err_next;
    end
  end

endmodule
